// File: rtl/bitserial_alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer and its 1-bit slice:
// function codes, sequencer state encoding and a funct legality helper.
package bitserial_alu_ctrl_pkg;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_SLT_FIX = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic logic is_legal_funct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/bitserial_alu_slice.sv
// One combinational ALU slice (AND/OR/ADD/SUB/SLT). Signal bit 1 inverts B,
// so SUB and SLT subtract when the carry-in of bit 0 is forced to 1.
// Lives beside the sequencer; the parent (or bench) wires the two together.
module bitserial_alu_slice
  import bitserial_alu_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [5:0] signal,
  output logic       sum,
  output logic       cout
);

  logic bb;

  // Operation select and full-adder carry out for the selected B polarity
  always_comb begin
    bb   = b ^ signal[1];
    cout = (a & bb) | (a & cin) | (bb & cin);
    case (signal)
      FN_AND:         sum = a & b;
      FN_OR:          sum = a | b;
      FN_ADD, FN_SUB: sum = a ^ bb ^ cin;
      FN_SLT:         sum = less;
      default:        sum = 1'b0;
    endcase
  end

endmodule

// File: rtl/bitserial_alu_ctrl.sv
// Bit-serial ALU sequencer: feeds an external 1-bit slice one operand bit per
// cycle (LSB first), collects Sum into the result register and threads the
// carry through a single flop. SLT runs a signed subtract, then spends one
// extra cycle pushing the overflow-corrected sign through the slice's Less input.
module bitserial_alu_ctrl
  import bitserial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_less,
  output logic [5:0]       slice_signal,
  input  logic             slice_sum,
  input  logic             slice_cout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             set_q, set_d;
  logic             illegal_q, illegal_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [5:0]       funct_q, funct_d;
  logic             ovf;

  // Next-state, bit-step datapath and slice drive
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    set_d        = set_q;
    illegal_d    = 1'b0;
    overflow_d   = overflow_q;
    result_d     = result_q;
    a_d          = a_q;
    b_d          = b_q;
    funct_d      = funct_q;
    ovf          = 1'b0;
    slice_a      = 1'b0;
    slice_b      = 1'b0;
    slice_cin    = 1'b0;
    slice_less   = 1'b0;
    slice_signal = 6'd0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_legal_funct(funct)) begin
            a_d        = a;
            b_d        = b;
            funct_d    = funct;
            idx_d      = '0;
            // Subtracting ops start with carry-in 1 to complete the two's complement of B
            carry_d    = funct[1];
            set_d      = 1'b0;
            overflow_d = 1'b0;
            state_d    = ST_RUN;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        slice_a      = a_q[idx_q];
        slice_b      = b_q[idx_q];
        slice_cin    = carry_q;
        slice_signal = (funct_q == FN_SLT) ? FN_SUB : funct_q;
        result_d[idx_q] = slice_sum;
        carry_d      = slice_cout;
        idx_d        = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          // Signed overflow: carry into the MSB differs from carry out of it
          ovf        = carry_q ^ slice_cout;
          overflow_d = ((funct_q == FN_ADD) || (funct_q == FN_SUB)) ? ovf : 1'b0;
          // True sign of a-b even when the subtraction overflowed
          set_d      = slice_sum ^ ovf;
          idx_d      = '0;
          state_d    = (funct_q == FN_SLT) ? ST_SLT_FIX : ST_DONE;
        end
      end

      ST_SLT_FIX: begin
        slice_a      = a_q[0];
        slice_b      = b_q[0];
        slice_cin    = 1'b1;
        slice_less   = set_q;
        slice_signal = FN_SLT;
        result_d     = {{(WIDTH-1){1'b0}}, slice_sum};
        state_d      = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and result registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      set_q      <= 1'b0;
      illegal_q  <= 1'b0;
      overflow_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      set_q      <= set_d;
      illegal_q  <= illegal_d;
      overflow_q <= overflow_d;
      result_q   <= result_d;
    end
  end

  // Latched operands and function code; only meaningful while an op runs
  always_ff @(posedge clk) begin
    a_q     <= a_d;
    b_q     <= b_d;
    funct_q <= funct_d;
  end

  assign busy     = (state_q == ST_RUN) || (state_q == ST_SLT_FIX);
  assign done     = (state_q == ST_DONE);
  assign illegal  = illegal_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bitserial_alu_ctrl.sv
// Bench for bitserial_alu_ctrl driving a real 1-bit slice at WIDTH=32.
module tb_bitserial_alu_ctrl;
  import bitserial_alu_ctrl_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   funct = 6'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, illegal, overflow;
  logic [W-1:0] result;
  logic         slice_a, slice_b, slice_cin, slice_less, slice_sum, slice_cout;
  logic [5:0]   slice_signal;

  bitserial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .illegal(illegal), .result(result),
    .overflow(overflow), .slice_a(slice_a), .slice_b(slice_b),
    .slice_cin(slice_cin), .slice_less(slice_less), .slice_signal(slice_signal),
    .slice_sum(slice_sum), .slice_cout(slice_cout)
  );

  bitserial_alu_slice u_slice (
    .a(slice_a), .b(slice_b), .cin(slice_cin), .less(slice_less),
    .signal(slice_signal), .sum(slice_sum), .cout(slice_cout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Issue one op, then watch negedges until done (bounded). lat counts edges
  // from the start edge to the edge that captures done.
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input bit inject, output logic [W-1:0] res, output logic ovf,
                        output int lat, output logic cin0, output logic [5:0] sig0,
                        output logic busy0);
    res = '0; ovf = 1'b0; lat = -1;
    @(negedge clk);
    start = 1'b1; funct = f; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0; funct = 6'd0; a = '0; b = '0;
    busy0 = busy; cin0 = slice_cin; sig0 = slice_signal;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      start = inject && (k == 5);
      funct = (inject && (k == 5)) ? FN_ADD : 6'd0;
      a     = (inject && (k == 5)) ? 32'd9 : 32'd0;
      b     = (inject && (k == 5)) ? 32'd9 : 32'd0;
      if (done) begin
        lat = k + 1;
        res = result;
        ovf = overflow;
        break;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [5:0] f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic       ovf;
    int         lat;
    logic       cin0;
  } vec_t;

  vec_t vt[9];

  logic [W-1:0] r;
  logic         o, c0, b0;
  logic [5:0]   s0;
  int           lat;
  bit           seen;

  initial begin
    vt[0] = '{"add_ovf",   FN_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 33, 1'b0};
    vt[1] = '{"sub_neg",   FN_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 33, 1'b1};
    vt[2] = '{"slt_m1_1",  FN_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 34, 1'b1};
    vt[3] = '{"slt_min_1", FN_SLT, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 34, 1'b1};
    vt[4] = '{"slt_1_m1",  FN_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34, 1'b1};
    vt[5] = '{"sub_ovf",   FN_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 33, 1'b1};
    vt[6] = '{"add_wrap",  FN_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 33, 1'b0};
    vt[7] = '{"and",       FN_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 33, 1'b0};
    vt[8] = '{"or",        FN_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 33, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    check("rst_slice_signal", slice_signal, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven ops
    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].f, vt[i].a, vt[i].b, 1'b0, r, o, lat, c0, s0, b0);
      check({vt[i].name, "_result"}, r, vt[i].res);
      check({vt[i].name, "_ovf"}, o, vt[i].ovf);
      check({vt[i].name, "_latency"}, lat, vt[i].lat);
      check({vt[i].name, "_busy"}, b0, 1);
      check({vt[i].name, "_cin_bit0"}, c0, vt[i].cin0);
      check({vt[i].name, "_signal"}, s0, (vt[i].f == FN_SLT) ? FN_SUB : vt[i].f);
      @(negedge clk);
      check({vt[i].name, "_done_pulse"}, {done, busy}, 2'b00);
    end

    // Illegal funct: pulse, no busy, result left from the OR op
    @(negedge clk);
    start = 1'b1; funct = 6'd0; a = 32'h1234; b = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    check("illegal_pulse", illegal, 1);
    check("illegal_busy", busy, 0);
    check("illegal_result", result, 32'hFFF0FFF0);
    @(negedge clk);
    check("illegal_one_cycle", illegal, 0);

    // Start during RUN is ignored
    run_op(FN_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, r, o, lat, c0, s0, b0);
    check("inject_result", r, 32'hF000F000);
    check("inject_latency", lat, 33);
    check("inject_illegal", illegal, 0);
    @(negedge clk);
    check("inject_idle", {done, busy}, 2'b00);

    // Reset mid-operation at idx=10
    @(negedge clk);
    start = 1'b1; funct = FN_ADD; a = 32'h12345678; b = 32'h11111111;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    check("midrst_done", done, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", seen, 0);

    run_op(FN_ADD, 32'd3, 32'd4, 1'b0, r, o, lat, c0, s0, b0);
    check("post_rst_add", r, 32'd7);
    check("post_rst_ovf", o, 0);
    check("post_rst_latency", lat, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
